// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern-detection run controller.
package seq_det_pkg;

  localparam int MAXLEN_DEF = 8;
  localparam int CNTW_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic cfg_valid(input int len, input int maxlen, input logic target_nz);
    if ((len >= 1) && (len <= maxlen) && target_nz) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/seq_det_ctrl_window.sv
// History shift register with saturating fill count and length-masked pattern compare.
module seq_window
  import seq_det_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF,
  localparam int LW    = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              bit_in,
  input  logic              clear_fill,
  input  logic              clear_all,
  input  logic [LW-1:0]     len,
  input  logic [MAXLEN-1:0] pattern,
  output logic              hit
);

  logic [MAXLEN-2:0] hist_q;
  logic [LW-1:0]     fill_q;
  logic [MAXLEN-1:0] window_s;
  logic [MAXLEN-1:0] mask_s;
  logic [LW:0]       fill_p1_s;

  assign window_s = {hist_q, bit_in};

  // Match when enough bits have arrived and the low len bits of the window equal the pattern.
  always_comb begin
    mask_s    = {MAXLEN{1'b0}};
    fill_p1_s = {1'b0, fill_q} + {{LW{1'b0}}, 1'b1};
    for (int i = 0; i < MAXLEN; i++) begin
      mask_s[i] = (i < int'(len));
    end
    if (shift && (len != {LW{1'b0}}) && (fill_p1_s >= {1'b0, len}) &&
        (((window_s ^ pattern) & mask_s) == {MAXLEN{1'b0}})) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

  // History and fill tracking; fill saturates so arbitrarily long runs never wrap.
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      hist_q <= {(MAXLEN-1){1'b0}};
      fill_q <= {LW{1'b0}};
    end else if (shift) begin
      hist_q <= window_s[MAXLEN-2:0];
      if (clear_fill) begin
        fill_q <= {LW{1'b0}};
      end else if (fill_q != LW'(MAXLEN)) begin
        fill_q <= fill_q + LW'(1);
      end else begin
        fill_q <= fill_q;
      end
    end else begin
      hist_q <= hist_q;
      fill_q <= fill_q;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller: shadow config, IDLE/RUN/DONE sequencing, match counting and
// registered status pulses around the seq_window compare datapath.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int CNTW   = CNTW_DEF,
  localparam int LW    = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_target,
  input  logic              start,
  input  logic              abort,
  input  logic              in,
  input  logic              in_valid,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [CNTW-1:0]   match_count,
  output logic              cfg_err
);

  state_e            state_q;
  logic [MAXLEN-1:0] pat_q;
  logic [LW-1:0]     len_q;
  logic              ovl_q;
  logic [CNTW-1:0]   tgt_q;
  logic [CNTW-1:0]   cnt_q;
  logic              busy_q, done_q, match_q, err_q;

  logic [LW-1:0]     len_d;
  logic [CNTW-1:0]   tgt_d;
  logic [CNTW-1:0]   cnt_d;
  logic              start_ok_s, shift_s, hit_s, clear_fill_s, clear_all_s;

  // A same-edge config write is what the start check must see.
  always_comb begin
    if (cfg_we) begin
      len_d = cfg_len;
      tgt_d = cfg_target;
    end else begin
      len_d = len_q;
      tgt_d = tgt_q;
    end
    start_ok_s   = cfg_valid(int'(len_d), MAXLEN, (tgt_d != {CNTW{1'b0}}));
    shift_s      = (state_q == RUN) && in_valid;
    cnt_d        = cnt_q + CNTW'(1);
    clear_fill_s = hit_s && !ovl_q;
    clear_all_s  = (state_q != RUN);
  end

  seq_window #(.MAXLEN(MAXLEN)) u_window (
    .clk        (clk),
    .rst        (rst),
    .shift      (shift_s),
    .bit_in     (in),
    .clear_fill (clear_fill_s),
    .clear_all  (clear_all_s),
    .len        (len_q),
    .pattern    (pat_q),
    .hit        (hit_s)
  );

  // Control FSM; DONE spans two cycles so done is a registered pulse before IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= {MAXLEN{1'b0}};
      len_q   <= {LW{1'b0}};
      ovl_q   <= 1'b0;
      tgt_q   <= {CNTW{1'b0}};
      cnt_q   <= {CNTW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_we) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            tgt_q <= cfg_target;
          end
          if (start) begin
            if (start_ok_s) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= {CNTW{1'b0}};
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (hit_s) begin
            match_q <= 1'b1;
            cnt_q   <= cnt_d;
            if (cnt_d == tgt_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (done_q) begin
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign match       = match_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a bit-queue reference model predicts match/done/cfg_err
// events, and a negedge monitor compares them against the pulses the DUT presents.
module tb_seq_det_ctrl;

  localparam int MAXLEN = 8;

  logic       clk = 1'b0;
  logic       rst, cfg_we, cfg_overlap, start, abort, in_s, in_valid;
  logic [7:0] cfg_pattern, cfg_target;
  logic [3:0] cfg_len;
  logic       busy, done, match, cfg_err;
  logic [7:0] match_count;

  seq_det_ctrl #(.MAXLEN(8), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .abort(abort),
    .in(in_s), .in_valid(in_valid), .busy(busy), .done(done), .match(match),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int cnt; } ev_t;  // kind: 0 match, 1 done, 2 cfg_err
  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  // Reference model state: 0 idle, 1 running, 2 finishing
  int         m_state = 0;
  int         m_done_left = 0;
  logic [7:0] m_pat = 8'd0;
  int         m_len = 0;
  bit         m_ovl = 1'b0;
  int         m_tgt = 0;
  int         m_cnt = 0;
  bit         m_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit();
    int n;
    n = m_hist.size();
    if (n < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      if (m_hist[n - m_len + j] != m_pat[m_len - 1 - j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input bit we, input logic [7:0] p, input int l, input bit o,
                            input int t, input bit st, input bit ab, input bit v, input bit b);
    case (m_state)
      0: begin
        if (we) begin m_pat = p; m_len = l; m_ovl = o; m_tgt = t; end
        if (st) begin
          if (m_len >= 1 && m_len <= MAXLEN && m_tgt != 0) begin
            m_state = 1; m_cnt = 0; m_hist.delete();
          end else begin
            exp_q.push_back(ev_t'{2, m_cnt});
          end
        end
      end
      1: begin
        if (ab) begin
          m_state = 0;
        end else if (v) begin
          m_hist.push_back(b);
          if (m_hit()) begin
            m_cnt++;
            exp_q.push_back(ev_t'{0, m_cnt});
            if (!m_ovl) m_hist.delete();
            if (m_cnt == m_tgt) begin
              exp_q.push_back(ev_t'{1, m_cnt});
              m_state = 2; m_done_left = 2;
            end
          end
        end
      end
      default: begin
        m_done_left--;
        if (m_done_left == 0) m_state = 0;
      end
    endcase
  endtask

  task automatic cyc(input bit we, input logic [7:0] p, input int l, input bit o, input int t,
                     input bit st, input bit ab, input bit v, input bit b);
    cfg_we = we; cfg_pattern = p; cfg_len = l[3:0]; cfg_overlap = o; cfg_target = t[7:0];
    start = st; abort = ab; in_valid = v; in_s = b;
    @(posedge clk);
    model_step(we, p, l, o, t, st, ab, v, b);
    #1;
    check("busy", {31'd0, busy}, {31'd0, m_state == 1});
    check("match_count", {24'd0, match_count}, m_cnt);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 8'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic bits(input logic [31:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(0, 8'd0, 0, 0, 0, 0, 0, 1, s[i]);
  endtask

  task automatic cfg_go(input logic [7:0] p, input int l, input bit o, input int t);
    cyc(1, p, l, o, t, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_s = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    @(posedge clk);
    m_state = 0; m_pat = 8'd0; m_len = 0; m_ovl = 1'b0; m_tgt = 0; m_cnt = 0; m_hist.delete();
    #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_outs", {27'd0, busy, done, match, cfg_err, |match_count}, 32'd0);
  endtask

  task automatic pop_check(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == 0) check("match_count_at_match", {24'd0, match_count}, e.cnt);
    end
  endtask

  // Monitor: every pulse the DUT presents must be the next predicted event.
  always @(negedge clk) begin
    if (match === 1'b1) pop_check(0);
    if (done === 1'b1) pop_check(1);
    if (cfg_err === 1'b1) pop_check(2);
  end

  initial begin
    logic [7:0] p;
    int         l, t, pos;
    bit         o, v, b;

    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = 8'd0; cfg_len = 4'd0; cfg_overlap = 1'b0;
    cfg_target = 8'd0; start = 1'b0; abort = 1'b0; in_s = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Non-overlapping 1011: one match after the 4th bit
    cfg_go(8'b1011, 4, 0, 5);
    bits(32'b101, 3);
    bits(32'b1, 1);
    check("t1_match_after_bit4", {31'd0, match}, 32'd1);
    bits(32'b011, 3);
    cyc(0, 8'd0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);

    // Overlapping: matches after bits 4 and 7; a cfg write during RUN is ignored
    cfg_go(8'b1011, 4, 1, 5);
    cyc(1, 8'd0, 0, 0, 0, 0, 0, 1, 1);
    bits(32'b011011, 6);
    cyc(0, 8'd0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);

    // Target 2 with an in_valid gap; check match/done/busy timing
    cfg_go(8'b1011, 4, 1, 2);
    bits(32'b1011, 4);
    check("t3_match1", {31'd0, match}, 32'd1);
    bits(32'b0, 1);
    idle(3);
    bits(32'b11, 2);
    check("t3_match2", {31'd0, match}, 32'd1);
    idle(1);
    check("t3_done", {31'd0, done}, 32'd1);
    idle(1);
    check("t3_done_once", {31'd0, done}, 32'd0);
    idle(2);

    // Invalid configs are rejected; count is unchanged
    cfg_go(8'b1011, 0, 0, 5);
    check("t4_err_len0", {31'd0, cfg_err}, 32'd1);
    cyc(1, 8'b1011, 4, 0, 0, 0, 0, 0, 0);
    cyc(0, 8'd0, 0, 0, 0, 1, 0, 0, 0);
    check("t4_err_tgt0", {31'd0, cfg_err}, 32'd1);
    idle(2);

    // Abort after 2 matches beats a coincident 3rd match
    cfg_go(8'b1011, 4, 1, 10);
    bits(32'b101101101, 9);
    cyc(0, 8'd0, 0, 0, 0, 0, 1, 1, 1);
    check("t5_abort_no_match", {31'd0, match}, 32'd0);
    idle(3);

    // Reset mid-run, then an unconfigured start is rejected
    cfg_go(8'b1011, 4, 0, 5);
    bits(32'b1011, 4);
    do_reset();
    cyc(0, 8'd0, 0, 0, 0, 1, 0, 0, 0);
    check("t5_err_after_rst", {31'd0, cfg_err}, 32'd1);
    idle(2);

    // Randomised runs: len 1 and len 8 corner patterns first, then random configs
    for (int it = 0; it < 12; it++) begin
      if (it < 2)      begin p = 8'h01; l = 1; o = it[0]; t = 60; end
      else if (it < 4) begin p = 8'hA5; l = 8; o = it[0]; t = 60; end
      else begin
        l = $urandom_range(1, 8); p = 8'($urandom); o = 1'($urandom); t = $urandom_range(1, 6);
      end
      cfg_go(p, l, o, t);
      pos = 0;
      for (int k = 0; k < 80; k++) begin
        v = ($urandom_range(0, 3) != 0);
        b = p[l - 1 - pos] ^ ($urandom_range(0, 5) == 0);
        if (v) pos = (pos + 1) % l;
        cyc(0, 8'd0, 0, 0, 0, 0, 0, v, b);
      end
      cyc(0, 8'd0, 0, 0, 0, 0, 1, 0, 0);
      idle(3);
    end

    idle(3);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
